// File: rtl/obi_xbar_arb_pkg.sv
// Shared types and helpers for the OBI crossbar with arbitration and an error responder.
package obi_xbar_arb_pkg;

  typedef enum logic {
    RR    = 1'b0,
    FIXED = 1'b1
  } arb_mode_e;

  localparam logic [31:0] ErrDataDefault = 32'hBADCAB1E;

  // Width of a target index; value num_mgr addresses the internal error responder.
  function automatic int unsigned sel_width(input int unsigned num_mgr);
    int unsigned w;
    w = $clog2(num_mgr + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/obi_xbar_arb_fifo.sv
// Synchronous FIFO holding the subordinate index of each accepted manager transaction.
module obi_xbar_arb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        do_push, do_pop;

  function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  // A full FIFO refuses the push even if the head retires in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = incr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = incr(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/obi_xbar_arb.sv
// OBI crossbar: address decode, per-manager arbitration, ordered response routing, error responder.
module obi_xbar_arb
  import obi_xbar_arb_pkg::*;
#(
  parameter int unsigned          NumSbrPorts  = 2,
  parameter int unsigned          NumMgrPorts  = 2,
  parameter int unsigned          AddrWidth    = 32,
  parameter int unsigned          DataWidth    = 32,
  parameter int unsigned          NumAddrRules = 2,
  parameter int unsigned          NumMaxTrans  = 4,
  parameter int unsigned          MgrFifoDepth = 4,
  parameter int unsigned          ArbMode      = 0,
  parameter logic [DataWidth-1:0] ErrData      = ErrDataDefault,
  localparam int unsigned         SelW         = sel_width(NumMgrPorts)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumSbrPorts-1:0]                   sbr_req_i,
  output logic [NumSbrPorts-1:0]                   sbr_gnt_o,
  input  logic [NumSbrPorts-1:0][AddrWidth-1:0]    sbr_addr_i,
  input  logic [NumSbrPorts-1:0]                   sbr_we_i,
  input  logic [NumSbrPorts-1:0][DataWidth/8-1:0]  sbr_be_i,
  input  logic [NumSbrPorts-1:0][DataWidth-1:0]    sbr_wdata_i,
  output logic [NumSbrPorts-1:0]                   sbr_rvalid_o,
  input  logic [NumSbrPorts-1:0]                   sbr_rready_i,
  output logic [NumSbrPorts-1:0][DataWidth-1:0]    sbr_rdata_o,
  output logic [NumSbrPorts-1:0]                   sbr_err_o,
  output logic [NumMgrPorts-1:0]                   mgr_req_o,
  input  logic [NumMgrPorts-1:0]                   mgr_gnt_i,
  output logic [NumMgrPorts-1:0][AddrWidth-1:0]    mgr_addr_o,
  output logic [NumMgrPorts-1:0]                   mgr_we_o,
  output logic [NumMgrPorts-1:0][DataWidth/8-1:0]  mgr_be_o,
  output logic [NumMgrPorts-1:0][DataWidth-1:0]    mgr_wdata_o,
  input  logic [NumMgrPorts-1:0]                   mgr_rvalid_i,
  output logic [NumMgrPorts-1:0]                   mgr_rready_o,
  input  logic [NumMgrPorts-1:0][DataWidth-1:0]    mgr_rdata_i,
  input  logic [NumMgrPorts-1:0]                   mgr_err_i,
  input  logic [NumAddrRules-1:0][SelW-1:0]        rule_idx_i,
  input  logic [NumAddrRules-1:0][AddrWidth-1:0]   rule_start_i,
  input  logic [NumAddrRules-1:0][AddrWidth-1:0]   rule_end_i,
  input  logic [NumSbrPorts-1:0]                   en_default_idx_i,
  input  logic [NumSbrPorts-1:0][SelW-1:0]         default_idx_i
);

  localparam int unsigned IdxW   = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1;
  localparam int unsigned CntW   = $clog2(NumMaxTrans + 1);
  localparam logic [SelW-1:0] ErrTgt = SelW'(NumMgrPorts);
  localparam arb_mode_e   Mode   = (ArbMode == 1) ? FIXED : RR;

  logic [NumSbrPorts-1:0][SelW-1:0] tgt_dec, tgt_q, tgt_d;
  logic [NumSbrPorts-1:0][CntW-1:0] cnt_q, cnt_d, err_cnt_q, err_cnt_d;
  logic [NumSbrPorts-1:0]           is_err, fwd, sbr_hs, sbr_rt;

  logic [NumMgrPorts-1:0][NumSbrPorts-1:0] cand;
  logic [NumMgrPorts-1:0][IdxW-1:0]        win, rr_q, rr_d, lock_idx_q, lock_idx_d, fifo_head;
  logic [NumMgrPorts-1:0]                  lock_vld_q, lock_vld_d, mgr_hs, mgr_pop;
  logic [NumMgrPorts-1:0]                  fifo_full, fifo_empty;

  // Decode: lowest-index matching rule wins; out-of-range indices go to the error responder.
  always_comb begin
    for (int s = 0; s < int'(NumSbrPorts); s++) begin
      tgt_dec[s] = en_default_idx_i[s] ? default_idx_i[s] : ErrTgt;
      for (int r = int'(NumAddrRules) - 1; r >= 0; r--) begin
        if (sbr_addr_i[s] >= rule_start_i[r] && sbr_addr_i[s] < rule_end_i[r]) begin
          tgt_dec[s] = rule_idx_i[r];
        end
      end
      if (tgt_dec[s] > ErrTgt) begin
        tgt_dec[s] = ErrTgt;
      end
      is_err[s] = (tgt_dec[s] == ErrTgt);
      // Only one target may be outstanding at a time, which keeps responses in order.
      fwd[s] = rst_ni && sbr_req_i[s] && (cnt_q[s] < CntW'(NumMaxTrans)) &&
               ((cnt_q[s] == '0) || (tgt_dec[s] == tgt_q[s]));
    end
  end

  always_comb begin
    for (int m = 0; m < int'(NumMgrPorts); m++) begin
      for (int s = 0; s < int'(NumSbrPorts); s++) begin
        cand[m][s] = fwd[s] && !is_err[s] && (tgt_dec[s] == SelW'(m));
      end
      win[m] = '0;
      for (int s = int'(NumSbrPorts) - 1; s >= 0; s--) begin
        if (cand[m][s]) win[m] = IdxW'(s);
      end
      if (Mode == RR) begin
        for (int s = int'(NumSbrPorts) - 1; s >= 0; s--) begin
          if (cand[m][s] && (IdxW'(s) >= rr_q[m])) win[m] = IdxW'(s);
        end
        // A request presented without grant keeps its slot until accepted.
        if (lock_vld_q[m] && cand[m][lock_idx_q[m]]) win[m] = lock_idx_q[m];
      end
      mgr_req_o[m]   = (|cand[m]) && !fifo_full[m];
      mgr_addr_o[m]  = mgr_req_o[m] ? sbr_addr_i[win[m]]  : '0;
      mgr_we_o[m]    = mgr_req_o[m] ? sbr_we_i[win[m]]    : 1'b0;
      mgr_be_o[m]    = mgr_req_o[m] ? sbr_be_i[win[m]]    : '0;
      mgr_wdata_o[m] = mgr_req_o[m] ? sbr_wdata_i[win[m]] : '0;
    end
  end

  always_comb begin
    for (int s = 0; s < int'(NumSbrPorts); s++) begin
      sbr_gnt_o[s] = is_err[s] && fwd[s];
    end
    for (int m = 0; m < int'(NumMgrPorts); m++) begin
      if (mgr_req_o[m] && mgr_gnt_i[m]) sbr_gnt_o[win[m]] = 1'b1;
    end
  end

  assign mgr_hs  = mgr_req_o & mgr_gnt_i;
  assign mgr_pop = mgr_rvalid_i & mgr_rready_o;

  for (genvar m = 0; m < NumMgrPorts; m++) begin : g_mgr
    obi_xbar_arb_fifo #(
      .Depth (MgrFifoDepth),
      .Width (IdxW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (mgr_hs[m]),
      .data_i  (win[m]),
      .pop_i   (mgr_pop[m]),
      .data_o  (fifo_head[m]),
      .full_o  (fifo_full[m]),
      .empty_o (fifo_empty[m])
    );

    a_rvalid_needs_route : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(mgr_rvalid_i[m] && fifo_empty[m]))
      else $error("obi_xbar_arb: rvalid on manager %0d with no transaction pending", m);
  end

  always_comb begin
    sbr_rvalid_o = '0;
    sbr_err_o    = '0;
    sbr_rdata_o  = '0;
    mgr_rready_o = '0;
    for (int m = 0; m < int'(NumMgrPorts); m++) begin
      if (rst_ni && !fifo_empty[m]) begin
        mgr_rready_o[m] = sbr_rready_i[fifo_head[m]];
        if (mgr_rvalid_i[m]) begin
          sbr_rvalid_o[fifo_head[m]] = 1'b1;
          sbr_rdata_o[fifo_head[m]]  = mgr_rdata_i[m];
          sbr_err_o[fifo_head[m]]    = mgr_err_i[m];
        end
      end
    end
    for (int s = 0; s < int'(NumSbrPorts); s++) begin
      if (rst_ni && (err_cnt_q[s] != '0)) begin
        sbr_rvalid_o[s] = 1'b1;
        sbr_err_o[s]    = 1'b1;
        sbr_rdata_o[s]  = ErrData;
      end
    end
  end

  assign sbr_hs = sbr_req_i & sbr_gnt_o;
  assign sbr_rt = sbr_rvalid_o & sbr_rready_i;

  always_comb begin
    for (int s = 0; s < int'(NumSbrPorts); s++) begin
      cnt_d[s]     = cnt_q[s];
      err_cnt_d[s] = err_cnt_q[s];
      tgt_d[s]     = sbr_hs[s] ? tgt_dec[s] : tgt_q[s];
      if (sbr_hs[s] && !sbr_rt[s]) begin
        cnt_d[s] = cnt_q[s] + 1'b1;
      end else if (!sbr_hs[s] && sbr_rt[s]) begin
        cnt_d[s] = cnt_q[s] - 1'b1;
      end
      if ((sbr_hs[s] && is_err[s]) && !(sbr_rt[s] && (err_cnt_q[s] != '0))) begin
        err_cnt_d[s] = err_cnt_q[s] + 1'b1;
      end else if (!(sbr_hs[s] && is_err[s]) && sbr_rt[s] && (err_cnt_q[s] != '0)) begin
        err_cnt_d[s] = err_cnt_q[s] - 1'b1;
      end
    end
    for (int m = 0; m < int'(NumMgrPorts); m++) begin
      rr_d[m]       = rr_q[m];
      lock_idx_d[m] = lock_idx_q[m];
      lock_vld_d[m] = 1'b0;
      if (mgr_hs[m]) begin
        rr_d[m] = (win[m] == IdxW'(NumSbrPorts - 1)) ? '0 : win[m] + 1'b1;
      end else if (mgr_req_o[m]) begin
        lock_vld_d[m] = (Mode == RR);
        lock_idx_d[m] = win[m];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      tgt_q      <= '0;
      rr_q       <= '0;
      lock_vld_q <= '0;
      lock_idx_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      tgt_q      <= tgt_d;
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_obi_xbar_arb.sv
// Directed bench: a round-robin/depth-4 crossbar and a fixed-priority/depth-2 crossbar.
module tb_obi_xbar_arb;

  localparam int unsigned NS = 2;
  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NS-1:0]              sbr_req, sbr_we, sbr_rready, en_def;
  logic [NS-1:0][AW-1:0]      sbr_addr;
  logic [NS-1:0][DW/8-1:0]    sbr_be;
  logic [NS-1:0][DW-1:0]      sbr_wdata;
  logic [NS-1:0][SW-1:0]      def_idx;
  logic [NM-1:0]              mgr_gnt, mgr_rvalid, mgr_err, fp_mgr_gnt, fp_mgr_rvalid;
  logic [NM-1:0][DW-1:0]      mgr_rdata;
  logic [NR-1:0][SW-1:0]      rule_idx;
  logic [NR-1:0][AW-1:0]      rule_start, rule_end;

  logic [NS-1:0]              sbr_gnt, sbr_rvalid, sbr_err, fp_sbr_gnt, fp_sbr_rvalid, fp_sbr_err;
  logic [NS-1:0][DW-1:0]      sbr_rdata, fp_sbr_rdata;
  logic [NM-1:0]              mgr_req, mgr_we, mgr_rready, fp_mgr_req, fp_mgr_we, fp_mgr_rready;
  logic [NM-1:0][AW-1:0]      mgr_addr, fp_mgr_addr;
  logic [NM-1:0][DW/8-1:0]    mgr_be, fp_mgr_be;
  logic [NM-1:0][DW-1:0]      mgr_wdata, fp_mgr_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  obi_xbar_arb #(
    .NumSbrPorts (NS), .NumMgrPorts (NM), .AddrWidth (AW), .DataWidth (DW),
    .NumAddrRules (NR), .NumMaxTrans (4), .MgrFifoDepth (4), .ArbMode (0)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .sbr_req_i (sbr_req), .sbr_gnt_o (sbr_gnt), .sbr_addr_i (sbr_addr), .sbr_we_i (sbr_we),
    .sbr_be_i (sbr_be), .sbr_wdata_i (sbr_wdata), .sbr_rvalid_o (sbr_rvalid),
    .sbr_rready_i (sbr_rready), .sbr_rdata_o (sbr_rdata), .sbr_err_o (sbr_err),
    .mgr_req_o (mgr_req), .mgr_gnt_i (mgr_gnt), .mgr_addr_o (mgr_addr), .mgr_we_o (mgr_we),
    .mgr_be_o (mgr_be), .mgr_wdata_o (mgr_wdata), .mgr_rvalid_i (mgr_rvalid),
    .mgr_rready_o (mgr_rready), .mgr_rdata_i (mgr_rdata), .mgr_err_i (mgr_err),
    .rule_idx_i (rule_idx), .rule_start_i (rule_start), .rule_end_i (rule_end),
    .en_default_idx_i (en_def), .default_idx_i (def_idx)
  );

  obi_xbar_arb #(
    .NumSbrPorts (NS), .NumMgrPorts (NM), .AddrWidth (AW), .DataWidth (DW),
    .NumAddrRules (NR), .NumMaxTrans (4), .MgrFifoDepth (2), .ArbMode (1)
  ) dut_fp (
    .clk_i (clk), .rst_ni (rst_n),
    .sbr_req_i (sbr_req), .sbr_gnt_o (fp_sbr_gnt), .sbr_addr_i (sbr_addr), .sbr_we_i (sbr_we),
    .sbr_be_i (sbr_be), .sbr_wdata_i (sbr_wdata), .sbr_rvalid_o (fp_sbr_rvalid),
    .sbr_rready_i (sbr_rready), .sbr_rdata_o (fp_sbr_rdata), .sbr_err_o (fp_sbr_err),
    .mgr_req_o (fp_mgr_req), .mgr_gnt_i (fp_mgr_gnt), .mgr_addr_o (fp_mgr_addr),
    .mgr_we_o (fp_mgr_we), .mgr_be_o (fp_mgr_be), .mgr_wdata_o (fp_mgr_wdata),
    .mgr_rvalid_i (fp_mgr_rvalid), .mgr_rready_o (fp_mgr_rready), .mgr_rdata_i (mgr_rdata),
    .mgr_err_i (mgr_err), .rule_idx_i (rule_idx), .rule_start_i (rule_start),
    .rule_end_i (rule_end), .en_default_idx_i (en_def), .default_idx_i (def_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    sbr_req    = '0;
    mgr_gnt    = '0;
    mgr_rvalid = '0;
    fp_mgr_gnt = '0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_rr [5];
  logic [1:0] exp_fp [5];

  initial begin
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    exp_fp = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    rst_n         = 1'b0;
    sbr_req       = '0;
    sbr_we        = '0;
    sbr_rready    = 2'b11;
    sbr_addr      = '0;
    sbr_be        = '0;
    sbr_wdata     = '0;
    en_def        = '0;
    def_idx       = '0;
    mgr_gnt       = '0;
    mgr_rvalid    = '0;
    mgr_err       = '0;
    mgr_rdata     = '0;
    fp_mgr_gnt    = '0;
    fp_mgr_rvalid = '0;
    rule_idx[0]   = 2'd1;
    rule_start[0] = 32'h1000_0000;
    rule_end[0]   = 32'h2000_0000;
    rule_idx[1]   = 2'd0;
    rule_start[1] = 32'h0000_0000;
    rule_end[1]   = 32'h1000_0000;
    tick();
    tick();

    // Held in reset: requests and grants must not pass.
    sbr_req     = 2'b11;
    sbr_addr[0] = 32'h0000_0100;
    sbr_addr[1] = 32'h0000_0100;
    mgr_gnt     = 2'b11;
    #1;
    chk("rst_sbr_gnt", 32'(sbr_gnt), 32'h0);
    chk("rst_mgr_req", 32'(mgr_req), 32'h0);
    chk("rst_rvalid", 32'(sbr_rvalid), 32'h0);
    chk("rst_mgr_rready", 32'(mgr_rready), 32'h0);
    do_reset();

    // Decode to mgr1 and error path.
    sbr_req     = 2'b01;
    sbr_addr[0] = 32'h1000_0000;
    mgr_gnt     = 2'b10;
    #1;
    chk("dec_mgr_req", 32'(mgr_req), 32'h2);
    chk("dec_sbr_gnt", 32'(sbr_gnt), 32'h1);
    chk("dec_mgr_addr", mgr_addr[1], 32'h1000_0000);
    tick();
    sbr_req       = 2'b00;
    mgr_gnt       = 2'b00;
    mgr_rvalid    = 2'b10;
    mgr_rdata[1]  = 32'h1234_5678;
    #1;
    chk("dec_rvalid", 32'(sbr_rvalid), 32'h1);
    chk("dec_rdata", sbr_rdata[0], 32'h1234_5678);
    chk("dec_mgr_rready", 32'(mgr_rready), 32'h2);
    tick();
    mgr_rvalid  = 2'b00;
    sbr_req     = 2'b01;
    sbr_addr[0] = 32'hF000_0000;
    #1;
    chk("err_gnt", 32'(sbr_gnt), 32'h1);
    chk("err_no_mgr_req", 32'(mgr_req), 32'h0);
    chk("err_rvalid_not_yet", 32'(sbr_rvalid), 32'h0);
    tick();
    sbr_req = 2'b00;
    #1;
    chk("err_rvalid", 32'(sbr_rvalid), 32'h1);
    chk("err_flag", 32'(sbr_err), 32'h1);
    chk("err_rdata", sbr_rdata[0], 32'hBADC_AB1E);
    tick();
    #1;
    chk("err_retired", 32'(sbr_rvalid), 32'h0);

    // Reset with three transactions outstanding.
    sbr_req     = 2'b01;
    sbr_addr[0] = 32'h0000_0200;
    mgr_gnt     = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_pre_gnt", 32'(sbr_gnt), 32'h1);
      tick();
    end
    do_reset();
    #1;
    chk("mid_fifo_empty", 32'(mgr_rready), 32'h0);
    chk("mid_no_rvalid", 32'(sbr_rvalid), 32'h0);
    sbr_req     = 2'b01;
    sbr_addr[0] = 32'h1000_0000;
    mgr_gnt     = 2'b10;
    #1;
    chk("mid_post_gnt", 32'(sbr_gnt), 32'h1);
    chk("mid_post_req", 32'(mgr_req), 32'h2);
    tick();
    sbr_req      = 2'b00;
    mgr_gnt      = 2'b00;
    mgr_rvalid   = 2'b10;
    mgr_rdata[1] = 32'h55AA_0001;
    #1;
    chk("mid_post_rvalid", 32'(sbr_rvalid), 32'h1);
    chk("mid_post_rdata", sbr_rdata[0], 32'h55AA_0001);
    tick();
    mgr_rvalid = 2'b00;

    // Contention on mgr0: round-robin vs fixed priority, then FIFO full.
    do_reset();
    sbr_req     = 2'b11;
    sbr_addr[0] = 32'h0000_0100;
    sbr_addr[1] = 32'h0000_0104;
    mgr_gnt     = 2'b01;
    fp_mgr_gnt  = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", 32'(sbr_gnt), 32'(exp_rr[i]));
      chk("fp_gnt", 32'(fp_sbr_gnt), 32'(exp_fp[i]));
      chk("fp_mgr_req", 32'(fp_mgr_req), (i < 2) ? 32'h1 : 32'h0);
      tick();
    end
    #1;
    chk("rr_fifo_full_req", 32'(mgr_req), 32'h0);

    // Ordering stall: second target withheld until the first response retires.
    do_reset();
    sbr_req     = 2'b01;
    sbr_addr[0] = 32'h0000_0300;
    mgr_gnt     = 2'b11;
    #1;
    chk("ord_first_gnt", 32'(sbr_gnt), 32'h1);
    tick();
    sbr_addr[0] = 32'h1000_0300;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ord_stall_gnt", 32'(sbr_gnt), 32'h0);
      chk("ord_stall_req", 32'(mgr_req), 32'h0);
      tick();
    end
    mgr_rvalid   = 2'b01;
    mgr_rdata[0] = 32'hCAFE_0001;
    #1;
    chk("ord_resp", 32'(sbr_rvalid), 32'h1);
    chk("ord_resp_data", sbr_rdata[0], 32'hCAFE_0001);
    chk("ord_still_stall", 32'(sbr_gnt), 32'h0);
    tick();
    mgr_rvalid = 2'b00;
    #1;
    chk("ord_release_req", 32'(mgr_req), 32'h2);
    chk("ord_release_gnt", 32'(sbr_gnt), 32'h1);
    tick();
    sbr_req      = 2'b00;
    mgr_rvalid   = 2'b10;
    mgr_rdata[1] = 32'hCAFE_0002;
    #1;
    chk("ord_second_resp", sbr_rdata[0], 32'hCAFE_0002);
    tick();
    mgr_rvalid = 2'b00;

    // Outstanding limit.
    do_reset();
    sbr_req     = 2'b01;
    sbr_addr[0] = 32'h0000_0400;
    mgr_gnt     = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lim_gnt", 32'(sbr_gnt), (i < 4) ? 32'h1 : 32'h0);
      tick();
    end

    // R-channel backpressure with a write passthrough.
    do_reset();
    sbr_req      = 2'b10;
    sbr_addr[1]  = 32'h1000_0040;
    sbr_we       = 2'b10;
    sbr_be[1]    = 4'hF;
    sbr_wdata[1] = 32'hDEAD_BEEF;
    mgr_gnt      = 2'b10;
    #1;
    chk("bp_gnt", 32'(sbr_gnt), 32'h2);
    chk("bp_we", 32'(mgr_we), 32'h2);
    chk("bp_wdata", mgr_wdata[1], 32'hDEAD_BEEF);
    chk("bp_be", 32'(mgr_be[1]), 32'hF);
    tick();
    sbr_req      = 2'b00;
    sbr_we       = 2'b00;
    mgr_gnt      = 2'b00;
    sbr_rready   = 2'b01;
    mgr_rvalid   = 2'b10;
    mgr_rdata[1] = 32'hA5A5_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_mgr_rready", 32'(mgr_rready), 32'h0);
      chk("bp_rvalid", 32'(sbr_rvalid), 32'h2);
      chk("bp_rdata", sbr_rdata[1], 32'hA5A5_0001);
      tick();
    end
    sbr_rready = 2'b11;
    #1;
    chk("bp_deliver_rready", 32'(mgr_rready), 32'h2);
    chk("bp_deliver_rvalid", 32'(sbr_rvalid), 32'h2);
    tick();
    mgr_rvalid = 2'b00;
    #1;
    chk("bp_done_rvalid", 32'(sbr_rvalid), 32'h0);
    chk("bp_fifo_empty", 32'(mgr_rready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
